fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 136 +++++++++++++
 tb/tb_fetch_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Fetch buffer: decouples the PC/instruction-cache front end from Decode with a
// small FIFO, and owns the registered Decode-stage instruction/PC outputs.
module fetch_buffer #(
   parameter int unsigned             WORD_SIZE  = 32,
   parameter int unsigned             DEPTH      = 4,
   parameter logic [WORD_SIZE-1:0]    PC_INITIAL = 32'h0000_1000,
   parameter logic [WORD_SIZE-1:0]    NOP        = 32'h0000_0013
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         RedirectE,
   input  logic [WORD_SIZE-1:0]         RedirectPCE,
   input  logic                         StallF,
   input  logic                         StallD,
   input  logic                         FlushD,
   output logic [WORD_SIZE-1:0]         PCF,
   input  logic [WORD_SIZE-1:0]         CacheInstr,
   input  logic                         CacheStall,
   output logic [WORD_SIZE-1:0]         InstrD,
   output logic [WORD_SIZE-1:0]         PCD,
   output logic [WORD_SIZE-1:0]         PCPlus4D,
   output logic                         ValidD,
   output logic [$clog2(DEPTH+1)-1:0]   QCount
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   typedef struct packed {
      logic [WORD_SIZE-1:0] pc;
      logic [WORD_SIZE-1:0] instr;
   } entry_t;

   entry_t               mem_q [DEPTH];
   entry_t               mem_d [DEPTH];
   logic [PW-1:0]        head_q, head_d;
   logic [PW-1:0]        tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic [WORD_SIZE-1:0] pcf_q, pcf_d;
   logic [WORD_SIZE-1:0] instr_d_q, instr_d_d;
   logic [WORD_SIZE-1:0] pc_d_q, pc_d_d;
   logic [WORD_SIZE-1:0] pc4_d_q, pc4_d_d;
   logic                 valid_d_q, valid_d_d;
   logic                 pop_c;
   logic                 acc_c;

   // Handshake: pop toward Decode, accept from the cache (a full queue accepts only while popping).
   always_comb begin
      pop_c = !StallD && !FlushD && !RedirectE && (count_q != '0);
      acc_c = !CacheStall && !StallF && !RedirectE &&
              ((count_q < CW'(DEPTH)) || pop_c);
   end

   // Next PC, queue bookkeeping and Decode-stage register loads; redirect wins over all stalls.
   always_comb begin
      pcf_d     = pcf_q;
      mem_d     = mem_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      instr_d_d = instr_d_q;
      pc_d_d    = pc_d_q;
      pc4_d_d   = pc4_d_q;
      valid_d_d = valid_d_q;

      if (RedirectE) begin
         pcf_d     = RedirectPCE;
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
         instr_d_d = NOP;
         valid_d_d = 1'b0;
      end else begin
         if (acc_c) begin
            mem_d[tail_q] = '{pc: pcf_q, instr: CacheInstr};
            tail_d        = tail_q + PW'(1);
            pcf_d         = pcf_q + WORD_SIZE'(4);
         end
         if (pop_c) begin
            head_d = head_q + PW'(1);
         end
         count_d = count_q + CW'(acc_c) - CW'(pop_c);

         if (FlushD) begin
            instr_d_d = NOP;
            valid_d_d = 1'b0;
         end else if (!StallD) begin
            if (pop_c) begin
               instr_d_d = mem_q[head_q].instr;
               pc_d_d    = mem_q[head_q].pc;
               pc4_d_d   = mem_q[head_q].pc + WORD_SIZE'(4);
               valid_d_d = 1'b1;
            end else begin
               instr_d_d = NOP;
               valid_d_d = 1'b0;
            end
         end
      end
   end

   // Control and Decode-stage state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcf_q     <= PC_INITIAL;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         instr_d_q <= NOP;
         pc_d_q    <= PC_INITIAL;
         pc4_d_q   <= PC_INITIAL + WORD_SIZE'(4);
         valid_d_q <= 1'b0;
      end else begin
         pcf_q     <= pcf_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         instr_d_q <= instr_d_d;
         pc_d_q    <= pc_d_d;
         pc4_d_q   <= pc4_d_d;
         valid_d_q <= valid_d_d;
      end
   end

   // Queue storage; contents are don't-care after reset since the count is cleared.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign PCF      = pcf_q;
   assign InstrD   = instr_d_q;
   assign PCD      = pc_d_q;
   assign PCPlus4D = pc4_d_q;
   assign ValidD   = valid_d_q;
   assign QCount   = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: cache returns PC + 0x1000_0000 as the instruction.
module tb_fetch_buffer;

   logic        clk;
   logic        rst;
   logic        RedirectE;
   logic [31:0] RedirectPCE;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
   logic [31:0] PCF;
   logic [31:0] CacheInstr;
   logic        CacheStall;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
   logic [2:0]  QCount;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP_W = 32'h0000_0013;

   fetch_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .RedirectE  (RedirectE),
      .RedirectPCE(RedirectPCE),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .PCF        (PCF),
      .CacheInstr (CacheInstr),
      .CacheStall (CacheStall),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD),
      .QCount     (QCount)
   );

   // Cache model: every address returns a recognisable word.
   assign CacheInstr = PCF + 32'h1000_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; RedirectE = 1'b0; RedirectPCE = '0;
      StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; CacheStall = 1'b0;

      // Reset values
      step();
      chk("rst_pcf",   PCF,      32'h0000_1000);
      chk("rst_qcnt",  32'(QCount), 32'd0);
      chk("rst_instr", InstrD,   NOP_W);
      chk("rst_pcd",   PCD,      32'h0000_1000);
      chk("rst_pc4",   PCPlus4D, 32'h0000_1004);
      chk("rst_valid", 32'(ValidD), 32'd0);

      // Streaming, no stalls
      rst = 1'b0;
      step();
      chk("s1_pcf",   PCF, 32'h0000_1004);
      chk("s1_qcnt",  32'(QCount), 32'd1);
      chk("s1_valid", 32'(ValidD), 32'd0);
      step();
      chk("s2_pcf",   PCF, 32'h0000_1008);
      chk("s2_instr", InstrD, 32'h1000_1000);
      chk("s2_pcd",   PCD, 32'h0000_1000);
      chk("s2_pc4",   PCPlus4D, 32'h0000_1004);
      chk("s2_valid", 32'(ValidD), 32'd1);
      chk("s2_qcnt",  32'(QCount), 32'd1);
      step();
      chk("s3_pcf",   PCF, 32'h0000_100C);
      chk("s3_instr", InstrD, 32'h1000_1004);

      // Decode stall from reset: queue saturates
      rst = 1'b1;
      step();
      rst = 1'b0; StallD = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk("sd_qcnt",  32'(QCount), 32'd4);
      chk("sd_pcf",   PCF, 32'h0000_1010);
      chk("sd_valid", 32'(ValidD), 32'd0);
      chk("sd_instr", InstrD, NOP_W);
      StallD = 1'b0;
      step();
      chk("rel1_instr", InstrD, 32'h1000_1000);
      chk("rel1_qcnt",  32'(QCount), 32'd4);
      chk("rel1_pcf",   PCF, 32'h0000_1014);
      step();
      chk("rel2_instr", InstrD, 32'h1000_1004);
      chk("rel2_pcd",   PCD, 32'h0000_1004);
      chk("rel2_qcnt",  32'(QCount), 32'd4);
      chk("rel2_pcf",   PCF, 32'h0000_1018);

      // Fetch stall drains one entry
      StallF = 1'b1;
      step();
      chk("sf_qcnt",  32'(QCount), 32'd3);
      chk("sf_pcf",   PCF, 32'h0000_1018);
      chk("sf_instr", InstrD, 32'h1000_1008);

      // Redirect with 3 queued, StallF also high
      RedirectE = 1'b1; RedirectPCE = 32'h0000_2000;
      step();
      chk("rd_pcf",   PCF, 32'h0000_2000);
      chk("rd_qcnt",  32'(QCount), 32'd0);
      chk("rd_valid", 32'(ValidD), 32'd0);
      chk("rd_instr", InstrD, NOP_W);
      chk("rd_pcd",   PCD, 32'h0000_1008);
      RedirectE = 1'b0; StallF = 1'b0;
      step();
      chk("rd1_pcf",   PCF, 32'h0000_2004);
      chk("rd1_valid", 32'(ValidD), 32'd0);
      step();
      chk("rd2_instr", InstrD, 32'h1000_2000);
      chk("rd2_pcd",   PCD, 32'h0000_2000);
      chk("rd2_valid", 32'(ValidD), 32'd1);

      // Decode hold, then cache miss while the queue drains
      StallD = 1'b1;
      step();
      step();
      chk("hold_instr", InstrD, 32'h1000_2000);
      chk("hold_qcnt",  32'(QCount), 32'd3);
      StallD = 1'b0; CacheStall = 1'b1;
      step(); step(); step();
      chk("cs3_instr", InstrD, 32'h1000_200C);
      chk("cs3_qcnt",  32'(QCount), 32'd0);
      step(); step();
      chk("cs5_qcnt",  32'(QCount), 32'd0);
      chk("cs5_valid", 32'(ValidD), 32'd0);
      chk("cs5_instr", InstrD, NOP_W);
      chk("cs5_pcf",   PCF, 32'h0000_2010);
      chk("cs5_pcd",   PCD, 32'h0000_200C);
      CacheStall = 1'b0;
      step();
      step();
      chk("cr_instr", InstrD, 32'h1000_2010);
      chk("cr_qcnt",  32'(QCount), 32'd1);

      // FlushD together with StallD (fetch held so the queue is observable)
      FlushD = 1'b1; StallD = 1'b1; StallF = 1'b1;
      step();
      chk("fl_instr", InstrD, NOP_W);
      chk("fl_valid", 32'(ValidD), 32'd0);
      chk("fl_qcnt",  32'(QCount), 32'd1);
      chk("fl_pcd",   PCD, 32'h0000_2010);
      FlushD = 1'b0; StallD = 1'b0; StallF = 1'b0;
      step();
      chk("fl1_instr", InstrD, 32'h1000_2014);
      chk("fl1_valid", 32'(ValidD), 32'd1);

      // Redirect and reset together
      RedirectE = 1'b1; RedirectPCE = 32'h0000_3000; rst = 1'b1;
      step();
      chk("rr_pcf",   PCF, 32'h0000_1000);
      chk("rr_qcnt",  32'(QCount), 32'd0);
      chk("rr_pcd",   PCD, 32'h0000_1000);
      chk("rr_pc4",   PCPlus4D, 32'h0000_1004);
      chk("rr_valid", 32'(ValidD), 32'd0);

      // PC wrap at the top of the address space
      rst = 1'b0; RedirectPCE = 32'hFFFF_FFFC;
      step();
      chk("wr_pcf0", PCF, 32'hFFFF_FFFC);
      RedirectE = 1'b0;
      step();
      chk("wr_pcf1", PCF, 32'h0000_0000);
      step();
      chk("wr_instr", InstrD, 32'h0FFF_FFFC);
      chk("wr_pcd",   PCD, 32'hFFFF_FFFC);
      chk("wr_pc4",   PCPlus4D, 32'h0000_0000);
      chk("wr_pcf2",  PCF, 32'h0000_0004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
